// File: rtl/anyedge_evt_pkg.sv
// Shared types and helpers for the any-edge event responder: edge-mode selection,
// edge qualification and the DELAY/CNT_W legality rule used at elaboration.
package anyedge_evt_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    function automatic logic edge_hit(edge_mode_e mode, logic prev, logic cur);
        case (mode)
            EDGE_RISE: return !prev && cur;
            EDGE_FALL: return prev && !cur;
            default:   return prev != cur;
        endcase
    endfunction

    // The wrap-safe equality compare on due stamps only holds while DELAY < 2**CNT_W.
    function automatic bit delay_legal(int delay, int cnt_w);
        return (delay >= 1) && (cnt_w >= 1) && (cnt_w < 32) &&
               ((64'd1 << cnt_w) > 64'(delay));
    endfunction

    function automatic bit is_pow2(int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/evt_due_fifo.sv
// Synchronous FIFO of due timestamps; a push is accepted while full when a pop
// happens in the same cycle, so the occupancy stays at DEPTH.
module evt_due_fifo #(
    parameter int  DEPTH = 4,
    parameter type ts_t  = logic [7:0],
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  ts_t         din,
    output ts_t         head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    ts_t           mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is left unreset; entries are only ever read below count, so
    // stale contents are harmless and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/anyedge_event_responder.sv
// Detects qualified edges on sig_i and emits a one-cycle evt_o exactly DELAY clocks
// later; outstanding responses are held in order as due timestamps in a small FIFO.
module anyedge_event_responder
    import anyedge_evt_pkg::*;
#(
    parameter int         DELAY     = 100,
    parameter int         DEPTH     = 4,
    parameter int         CNT_W     = 8,
    parameter edge_mode_e EDGE_MODE = EDGE_ANY,
    localparam int        PW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_i,
    output logic          evt_o,
    output logic [PW-1:0] pending_o,
    output logic          full_o,
    output logic          ovf_o
);

    typedef logic [CNT_W-1:0] ts_t;
    localparam ts_t DELAY_TS = ts_t'(DELAY);

    if (!delay_legal(DELAY, CNT_W)) begin : g_bad_delay
        $error("anyedge_event_responder: DELAY must be in 1..2**CNT_W-1");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("anyedge_event_responder: DEPTH must be a power of 2, >= 2");
    end

    logic sig_q;
    ts_t  now;
    ts_t  head;
    logic edge_seen;
    logic fire;
    logic empty;
    logic full;

    assign edge_seen = edge_hit(EDGE_MODE, sig_q, sig_i);
    // Stamps enter in monotone order, so only the oldest one can be due now.
    assign fire      = !empty && (head == now);
    assign full_o    = full;

    evt_due_fifo #(
        .DEPTH (DEPTH),
        .ts_t  (ts_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (edge_seen),
        .pop   (fire),
        .din   (now + DELAY_TS),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (pending_o)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, as the hardware does.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= sig_i;
            now   <= '0;
            evt_o <= 1'b0;
            ovf_o <= 1'b0;
        end else begin
            sig_q <= sig_i;
            now   <= now + 1'b1;
            evt_o <= fire;
            if (edge_seen && full && !fire) ovf_o <= 1'b1;
        end
    end

endmodule
